// File: rtl/fft_bypass_buf.sv
// Frame buffer standing in for an FFT core: fills POINTS samples, idles PROC_LAT
// cycles, then drains the same samples in natural or bit-reversed order.
module fft_bypass_buf #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned POINTS         = 256,
  parameter int unsigned PROC_LAT       = 4,
  parameter int unsigned BITREV         = 0,
  parameter int unsigned DEBUG_BUS_SIZE = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     datai,
  input  logic                      fft_datai_valid,
  input  logic                      fft_read_outp,
  output logic                      fft_buf_rdy,
  output logic                      fft_outp_rdy,
  output logic [DATA_WIDTH-1:0]     datao,
  output logic                      fft_datao_valid,
  output logic                      drop,
  output logic [DEBUG_BUS_SIZE-1:0] debug
);

  localparam int unsigned ADDR_W    = $clog2(POINTS);
  localparam int unsigned PCNT_W    = (PROC_LAT > 1) ? $clog2(PROC_LAT) : 1;
  localparam int unsigned PCNT_LAST = (PROC_LAT > 0) ? PROC_LAT - 1 : 0;

  typedef enum logic [1:0] {
    FILL   = 2'b00,
    PROC   = 2'b01,
    UNUSED = 2'b10,
    DRAIN  = 2'b11
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_wr_cnt, w_wr_cnt_nxt;
  logic [ADDR_W-1:0]   r_rd_cnt, w_rd_cnt_nxt;
  logic [PCNT_W-1:0]   r_proc_cnt, w_proc_cnt_nxt;
  logic                w_wr_en, w_rd_en, w_drop;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [DATA_WIDTH-1:0] r_mem [POINTS];
  logic [DATA_WIDTH-1:0] r_datao;
  logic                r_valid, r_drop, r_drop_sticky;

  function automatic logic [ADDR_W-1:0] bit_rev(input logic [ADDR_W-1:0] a);
    for (int i = 0; i < int'(ADDR_W); i++) bit_rev[i] = a[ADDR_W-1-i];
  endfunction

  // Next-state and counter logic; counters wrap to zero on the terminal access.
  always_comb begin
    w_state_nxt    = r_state;
    w_wr_cnt_nxt   = r_wr_cnt;
    w_rd_cnt_nxt   = r_rd_cnt;
    w_proc_cnt_nxt = r_proc_cnt;
    w_wr_en        = 1'b0;
    w_rd_en        = 1'b0;
    case (r_state)
      FILL: begin
        if (fft_datai_valid) begin
          w_wr_en      = 1'b1;
          w_wr_cnt_nxt = r_wr_cnt + ADDR_W'(1);
          if (r_wr_cnt == ADDR_W'(POINTS - 1)) begin
            w_wr_cnt_nxt = '0;
            w_state_nxt  = (PROC_LAT == 0) ? DRAIN : PROC;
          end
        end
      end
      PROC: begin
        if (r_proc_cnt == PCNT_W'(PCNT_LAST)) begin
          w_proc_cnt_nxt = '0;
          w_state_nxt    = DRAIN;
        end else begin
          w_proc_cnt_nxt = r_proc_cnt + PCNT_W'(1);
        end
      end
      DRAIN: begin
        if (fft_read_outp) begin
          w_rd_en      = 1'b1;
          w_rd_cnt_nxt = r_rd_cnt + ADDR_W'(1);
          if (r_rd_cnt == ADDR_W'(POINTS - 1)) begin
            w_rd_cnt_nxt = '0;
            w_state_nxt  = FILL;
          end
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  assign w_rd_addr = (BITREV != 0) ? bit_rev(r_rd_cnt) : r_rd_cnt;
  assign w_drop    = fft_datai_valid && (r_state != FILL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= FILL;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_proc_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_cnt   <= w_wr_cnt_nxt;
      r_rd_cnt   <= w_rd_cnt_nxt;
      r_proc_cnt <= w_proc_cnt_nxt;
    end
  end

  // Sample storage, deliberately without reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_cnt] <= datai;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_datao       <= '0;
      r_valid       <= 1'b0;
      r_drop        <= 1'b0;
      r_drop_sticky <= 1'b0;
    end else begin
      r_valid       <= w_rd_en;
      r_drop        <= w_drop;
      r_drop_sticky <= r_drop_sticky | w_drop;
      if (w_rd_en) r_datao <= r_mem[w_rd_addr];
    end
  end

  assign fft_buf_rdy     = (r_state == FILL);
  assign fft_outp_rdy    = (r_state == DRAIN);
  assign datao           = r_datao;
  assign fft_datao_valid = r_valid;
  assign drop            = r_drop;
  assign debug           = DEBUG_BUS_SIZE'({fft_outp_rdy, r_drop_sticky, r_state});

endmodule

// File: tb/tb_fft_bypass_buf.sv
// Directed bench for fft_bypass_buf: natural order (a), bit-reversed (b) and
// zero processing latency (c) instances share the write-side stimulus.
module tb_fft_bypass_buf;

  logic        clk = 1'b0;
  logic        rst, wr, rd, rd_c;
  logic [15:0] din;

  logic        buf_a, outp_a, val_a, drop_a;
  logic        buf_b, outp_b, val_b, drop_b;
  logic        buf_c, outp_c, val_c, drop_c;
  logic [15:0] dat_a, dat_b, dat_c;
  logic [3:0]  dbg_a, dbg_b, dbg_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fft_bypass_buf #(.DATA_WIDTH(16), .POINTS(8), .PROC_LAT(2), .BITREV(0), .DEBUG_BUS_SIZE(4)) u_a (
    .clk(clk), .rst(rst), .datai(din), .fft_datai_valid(wr), .fft_read_outp(rd),
    .fft_buf_rdy(buf_a), .fft_outp_rdy(outp_a), .datao(dat_a), .fft_datao_valid(val_a),
    .drop(drop_a), .debug(dbg_a));

  fft_bypass_buf #(.DATA_WIDTH(16), .POINTS(8), .PROC_LAT(2), .BITREV(1), .DEBUG_BUS_SIZE(4)) u_b (
    .clk(clk), .rst(rst), .datai(din), .fft_datai_valid(wr), .fft_read_outp(rd),
    .fft_buf_rdy(buf_b), .fft_outp_rdy(outp_b), .datao(dat_b), .fft_datao_valid(val_b),
    .drop(drop_b), .debug(dbg_b));

  fft_bypass_buf #(.DATA_WIDTH(16), .POINTS(8), .PROC_LAT(0), .BITREV(0), .DEBUG_BUS_SIZE(4)) u_c (
    .clk(clk), .rst(rst), .datai(din), .fft_datai_valid(wr), .fft_read_outp(rd_c),
    .fft_buf_rdy(buf_c), .fft_outp_rdy(outp_c), .datao(dat_c), .fft_datao_valid(val_c),
    .drop(drop_c), .debug(dbg_c));

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] din;
    logic        e_buf;
    logic        e_outp;
    logic        e_val;
    logic [15:0] e_dat;
    logic [15:0] e_datb;
    logic        e_outp_c;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] br_order [8];
    int n;
    br_order[0] = 16'h10; br_order[1] = 16'h14; br_order[2] = 16'h12; br_order[3] = 16'h16;
    br_order[4] = 16'h11; br_order[5] = 16'h15; br_order[6] = 16'h13; br_order[7] = 16'h17;

    // Fill 0x10..0x17, two PROC cycles (one with an ignored read), drain, ignored read in FILL.
    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b1, 1'b0, 16'(16'h10 + i), (i < 7), 1'b0, 1'b0, 16'h0, 16'h0, (i == 7)};
    vecs[8] = '{1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1};
    vecs[9] = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b1};
    for (int k = 0; k < 8; k++)
      vecs[10+k] = '{1'b0, 1'b1, 16'h0, (k == 7), (k != 7), 1'b1, 16'(16'h10 + k), br_order[k], 1'b1};
    vecs[18] = '{1'b0, 1'b1, 16'h0, 1'b1, 1'b0, 1'b0, 16'h17, 16'h17, 1'b1};

    rst = 1'b1; wr = 1'b0; rd = 1'b0; rd_c = 1'b0; din = '0;
    #1;
    check("rst buf_rdy", 32'(buf_a), 1);
    check("rst outp_rdy", 32'(outp_a), 0);
    check("rst valid", 32'(val_a), 0);
    check("rst drop", 32'(drop_a), 0);
    check("rst datao", 32'(dat_a), 0);
    check("rst debug", 32'(dbg_a), 0);
    step();
    step();
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      wr = vecs[i].wr; rd = vecs[i].rd; din = vecs[i].din;
      step();
      check($sformatf("row%0d buf_rdy", i), 32'(buf_a), 32'(vecs[i].e_buf));
      check($sformatf("row%0d outp_rdy", i), 32'(outp_a), 32'(vecs[i].e_outp));
      check($sformatf("row%0d valid", i), 32'(val_a), 32'(vecs[i].e_val));
      check($sformatf("row%0d datao", i), 32'(dat_a), 32'(vecs[i].e_dat));
      check($sformatf("row%0d drop", i), 32'(drop_a), 0);
      check($sformatf("row%0d bitrev valid", i), 32'(val_b), 32'(vecs[i].e_val));
      check($sformatf("row%0d bitrev datao", i), 32'(dat_b), 32'(vecs[i].e_datb));
      check($sformatf("row%0d lat0 outp_rdy", i), 32'(outp_c), 32'(vecs[i].e_outp_c));
    end
    wr = 1'b0; rd = 1'b0;

    // Writes during PROC and DRAIN are dropped; the coincident read is still serviced.
    for (int i = 0; i < 8; i++) begin
      wr = 1'b1; din = 16'(16'h30 + i);
      step();
    end
    din = 16'hAA;
    step();
    check("proc drop", 32'(drop_a), 1);
    check("proc debug", 32'(dbg_a), 32'h5);
    wr = 1'b0;
    step();
    check("drop clears", 32'(drop_a), 0);
    check("drain entry", 32'(outp_a), 1);
    wr = 1'b1; rd = 1'b1; din = 16'hBB;
    step();
    check("coinc valid", 32'(val_a), 1);
    check("coinc datao", 32'(dat_a), 32'h30);
    check("coinc drop", 32'(drop_a), 1);
    check("coinc debug", 32'(dbg_a), 32'hF);
    wr = 1'b0;
    for (int k = 1; k < 8; k++) begin
      step();
      check($sformatf("drain2 datao%0d", k), 32'(dat_a), 32'(16'h30 + k));
      check($sformatf("drain2 valid%0d", k), 32'(val_a), 1);
    end
    check("drain2 end outp", 32'(outp_a), 0);
    rd = 1'b0;
    step();
    check("hold datao", 32'(dat_a), 32'h37);
    check("hold valid", 32'(val_a), 0);
    check("sticky debug", 32'(dbg_a), 32'h4);

    // Reset mid-frame discards the partial frame.
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1; din = 16'(16'h40 + i);
      step();
    end
    wr = 1'b0; rst = 1'b1;
    #1;
    check("mid rst buf_rdy", 32'(buf_a), 1);
    check("mid rst datao", 32'(dat_a), 0);
    check("mid rst debug", 32'(dbg_a), 0);
    check("mid rst lat0 outp", 32'(outp_c), 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr = 1'b1; din = 16'(16'h20 + i);
      step();
    end
    wr = 1'b0;
    check("refill buf_rdy", 32'(buf_a), 0);
    check("lat0 buf_rdy", 32'(buf_c), 0);
    check("lat0 outp_rdy", 32'(outp_c), 1);
    n = 0;
    while (!outp_a && n < 10) begin
      step();
      n++;
    end
    check("proc length", 32'(n), 2);
    rd = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("drain3 datao%0d", k), 32'(dat_a), 32'(16'h20 + k));
      check($sformatf("drain3 valid%0d", k), 32'(val_a), 1);
    end
    rd = 1'b0;
    step();
    check("drain3 buf_rdy", 32'(buf_a), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
